// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
// bus_lvl() gives the SCL/SDA drive for a given state, quarter-phase and data bit.
package i2c_pkg;

    localparam int BIT_W  = 8;
    localparam int ADDR_W = 7;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_NACK,
        STOP
    } state_e;

    // Returns {scl, sda_oe, sda_out}
    function automatic logic [2:0] bus_lvl(state_e st, logic [1:0] q, logic b);
        logic scl_l;
        logic oe;
        logic out;
        scl_l = (q == Q1) || (q == Q2);
        oe    = 1'b0;
        out   = 1'b1;
        case (st)
            IDLE: scl_l = 1'b1;
            START: begin
                scl_l = (q != Q3);
                oe    = (q == Q2) || (q == Q3);
                out   = !oe;
            end
            ADDR, WRITE: begin
                oe  = 1'b1;
                out = b;
            end
            READ_NACK: oe = 1'b1;
            STOP: begin
                scl_l = (q != Q0);
                oe    = (q == Q0) || (q == Q1);
                out   = !oe;
            end
            default: ;
        endcase
        return {scl_l, oe, out};
    endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase generator: a CLK_DIV down-counter whose terminal count
// ends each quarter and advances the quarter index while run is high.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic [1:0] quarter,
    output logic       tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            quarter <= Q0;
        end else if (!run) begin
            cnt     <= RELOAD;
            quarter <= Q0;
        end else if (tick) begin
            cnt     <= RELOAD;
            quarter <= quarter + 2'd1;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP.
// Bus outputs are registered one cycle ahead from the next quarter-phase.
//
//   state     | meaning
//   IDLE      | bus released, waiting for start
//   START     | SDA falls while SCL high
//   ADDR      | shift out addr[6:0] then rw
//   ADDR_ACK  | release SDA, sample slave ACK
//   WRITE     | shift out wdata MSB first
//   WRITE_ACK | release SDA, data ACK sampled but ignored
//   READ      | release SDA, shift sda_in into rx byte
//   READ_NACK | master drives NACK (SDA high)
//   STOP      | SDA rises while SCL high, then done
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BIT_W-1:0]  wdata,
    input  logic              sda_in,
    output logic              scl,
    output logic              sda_out,
    output logic              sda_oe,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic [BIT_W-1:0]  rdata
);

    state_e           state;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_nxt;
    logic [BIT_W-1:0] addr_rw;
    logic [BIT_W-1:0] wdata_q;
    logic [BIT_W-1:0] rx_sr;
    logic [BIT_W-1:0] tx_byte;
    logic [1:0]       quarter;
    logic [1:0]       q_nxt;
    logic             tick;
    logic             bit_end;
    logic             smp;
    logic             ack_bit;
    logic             tx_bit_cur;
    logic             tx_bit_nxt;

    i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk     (clk),
        .reset   (reset),
        .run     (busy),
        .quarter (quarter),
        .tick    (tick)
    );

    assign q_nxt      = tick ? quarter + 2'd1 : quarter;
    assign bit_end    = tick && (quarter == Q3);
    assign smp        = tick && (quarter == Q1);
    assign bit_nxt    = bit_cnt + 3'd1;
    assign tx_byte    = (state == WRITE) ? wdata_q : addr_rw;
    assign tx_bit_cur = tx_byte[~bit_cnt];
    assign tx_bit_nxt = tx_byte[~bit_nxt];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            addr_rw <= '0;
            wdata_q <= '0;
            rx_sr   <= '0;
            ack_bit <= 1'b0;
            scl     <= 1'b1;
            sda_out <= 1'b1;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            {scl, sda_oe, sda_out} <= bus_lvl(state, q_nxt, tx_bit_cur);
            case (state)
                IDLE: begin
                    // The done cycle is still a busy cycle as far as the host is concerned.
                    if (start && !done) begin
                        addr_rw <= {addr, rw};
                        wdata_q <= wdata;
                        ack_err <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= ADDR;
                        {scl, sda_oe, sda_out} <= bus_lvl(ADDR, Q0, addr_rw[BIT_W-1]);
                    end
                end
                ADDR, WRITE: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (state == ADDR) state <= ADDR_ACK;
                            else               state <= WRITE_ACK;
                            {scl, sda_oe, sda_out} <= bus_lvl(ADDR_ACK, Q0, 1'b1);
                        end else begin
                            bit_cnt <= bit_nxt;
                            {scl, sda_oe, sda_out} <= bus_lvl(state, Q0, tx_bit_nxt);
                        end
                    end
                end
                ADDR_ACK: begin
                    if (smp) ack_bit <= sda_in;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (ack_bit) begin
                            ack_err <= 1'b1;
                            state   <= STOP;
                            {scl, sda_oe, sda_out} <= bus_lvl(STOP, Q0, 1'b0);
                        end else if (addr_rw[0]) begin
                            state <= READ;
                            {scl, sda_oe, sda_out} <= bus_lvl(READ, Q0, 1'b1);
                        end else begin
                            state <= WRITE;
                            {scl, sda_oe, sda_out} <= bus_lvl(WRITE, Q0, wdata_q[BIT_W-1]);
                        end
                    end
                end
                WRITE_ACK: begin
                    if (smp) ack_bit <= sda_in;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                        {scl, sda_oe, sda_out} <= bus_lvl(STOP, Q0, 1'b0);
                    end
                end
                READ: begin
                    if (smp) rx_sr <= {rx_sr[BIT_W-2:0], sda_in};
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= READ_NACK;
                            {scl, sda_oe, sda_out} <= bus_lvl(READ_NACK, Q0, 1'b1);
                        end else begin
                            bit_cnt <= bit_nxt;
                        end
                    end
                end
                READ_NACK: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                        {scl, sda_oe, sda_out} <= bus_lvl(STOP, Q0, 1'b0);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (addr_rw[0] && !ack_err) rdata <= rx_sr;
                        {scl, sda_oe, sda_out} <= bus_lvl(IDLE, Q0, 1'b1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: a small slave model per instance
// answers ACK/read data, and a bus monitor logs SDA at every SCL rise.
module tb_i2c_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_w   [2];
    logic       rw_w      [2];
    logic [6:0] addr_w    [2];
    logic [7:0] wdata_w   [2];
    logic       scl_w     [2];
    logic       sda_out_w [2];
    logic       sda_oe_w  [2];
    logic       busy_w    [2];
    logic       done_w    [2];
    logic       ack_err_w [2];
    logic [7:0] rdata_w   [2];
    logic       sda_bus   [2];
    logic       slave_w   [2];
    logic       ack_addr  [2];
    logic       rd_mode   [2];
    logic [7:0] rd_byte   [2];

    int n_chk  = 0;
    int n_pass = 0;
    int lat;
    int n;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(4)) dut (
        .clk(clk), .reset(rst_n), .start(start_w[0]), .rw(rw_w[0]),
        .addr(addr_w[0]), .wdata(wdata_w[0]), .sda_in(sda_bus[0]),
        .scl(scl_w[0]), .sda_out(sda_out_w[0]), .sda_oe(sda_oe_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .ack_err(ack_err_w[0]), .rdata(rdata_w[0])
    );

    i2c_master_ctrl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(rst_n), .start(start_w[1]), .rw(rw_w[1]),
        .addr(addr_w[1]), .wdata(wdata_w[1]), .sda_in(sda_bus[1]),
        .scl(scl_w[1]), .sda_out(sda_out_w[1]), .sda_oe(sda_oe_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .ack_err(ack_err_w[1]), .rdata(rdata_w[1])
    );

    for (genvar g = 0; g < 2; g++) begin : mon
        logic        scl_p    = 1'b1;
        logic        sda_p    = 1'b1;
        int          fcnt     = 31;
        int          rise_n   = 0;
        int          hi_chg   = 0;
        logic [31:0] rise_sr  = '0;
        logic [1:0]  nack_drv = '0;

        // fcnt counts SCL falls since START; slot 9 is the address ACK.
        assign slave_w[g] = (fcnt == 9) ? ack_addr[g] :
                            (rd_mode[g] && fcnt >= 10 && fcnt <= 17) ? rd_byte[g][3'(17 - fcnt)] :
                            (!rd_mode[g] && fcnt == 18) ? 1'b0 : 1'b1;
        assign sda_bus[g] = sda_oe_w[g] ? sda_out_w[g] : slave_w[g];

        always @(negedge clk) begin
            scl_p <= scl_w[g];
            sda_p <= sda_bus[g];
            if (scl_w[g] && scl_p && (sda_bus[g] != sda_p) && !sda_bus[g]) begin
                fcnt     <= 0;
                rise_n   <= 0;
                rise_sr  <= '0;
                hi_chg   <= 1;
                nack_drv <= '0;
            end else begin
                if (scl_w[g] && scl_p && (sda_bus[g] != sda_p)) begin
                    hi_chg <= hi_chg + 1;
                    fcnt   <= 31;
                end
                if (!scl_w[g] && scl_p) fcnt <= fcnt + 1;
                if (scl_w[g] && !scl_p) begin
                    rise_sr <= {rise_sr[30:0], sda_bus[g]};
                    rise_n  <= rise_n + 1;
                    if (fcnt == 18) nack_drv <= {sda_oe_w[g], sda_out_w[g]};
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issues one transaction on instance g and returns clocks from accept to done.
    task automatic txn(input int g, input logic r, input logic [6:0] a,
                       input logic [7:0] d, input bit poke, output int lt);
        @(negedge clk);
        rw_w[g] = r; addr_w[g] = a; wdata_w[g] = d; start_w[g] = 1'b1;
        @(negedge clk);
        start_w[g] = 1'b0;
        lt = 0;
        while (!done_w[g] && lt < 2000) begin
            @(negedge clk);
            lt++;
            if (poke && lt == 100) begin
                addr_w[g] = ~a; wdata_w[g] = ~d; rw_w[g] = ~r; start_w[g] = 1'b1;
            end else begin
                start_w[g] = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_w[i] = 1'b0; rw_w[i] = 1'b0; addr_w[i] = '0; wdata_w[i] = '0;
            ack_addr[i] = 1'b0; rd_mode[i] = 1'b0; rd_byte[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_scl",     scl_w[0],     1);
        chk("rst_sda_out", sda_out_w[0], 1);
        chk("rst_sda_oe",  sda_oe_w[0],  0);
        chk("rst_busy",    busy_w[0],    0);
        chk("rst_done",    done_w[0],    0);
        chk("rst_ack_err", ack_err_w[0], 0);
        chk("rst_rdata",   rdata_w[0],   0);
        rst_n = 1'b1;

        txn(0, 1'b0, 7'h5A, 8'hB5, 1'b0, lat);
        chk("wr_latency", lat, 320);
        chk("wr_ack_err", ack_err_w[0], 0);
        chk("wr_busy_at_done", busy_w[0], 0);
        chk("wr_bits", mon[0].rise_sr, 32'({8'hB4, 1'b0, 8'hB5, 1'b0, 1'b0}));
        chk("wr_rise_count", mon[0].rise_n, 19);
        chk("wr_sda_hi_changes", mon[0].hi_chg, 2);
        @(negedge clk);
        chk("wr_done_pulse", done_w[0], 0);

        rd_mode[0] = 1'b1; rd_byte[0] = 8'h3C;
        txn(0, 1'b1, 7'h21, 8'h00, 1'b0, lat);
        chk("rd_latency", lat, 320);
        chk("rd_rdata", rdata_w[0], 8'h3C);
        chk("rd_ack_err", ack_err_w[0], 0);
        chk("rd_master_nack", mon[0].nack_drv, 2'b11);
        chk("rd_bits", mon[0].rise_sr, 32'({8'h43, 1'b0, 8'h3C, 1'b1, 1'b0}));
        @(negedge clk);

        rd_mode[0] = 1'b0; ack_addr[0] = 1'b1;
        txn(0, 1'b0, 7'h10, 8'hAA, 1'b0, lat);
        chk("nack_latency", lat, 176);
        chk("nack_ack_err", ack_err_w[0], 1);
        chk("nack_bits", mon[0].rise_sr, 32'({8'h20, 1'b1, 1'b0}));
        chk("nack_rise_count", mon[0].rise_n, 10);
        chk("nack_rdata_held", rdata_w[0], 8'h3C);
        @(negedge clk);
        chk("nack_ack_err_held", ack_err_w[0], 1);
        ack_addr[0] = 1'b0;

        txn(0, 1'b0, 7'h33, 8'h96, 1'b1, lat);
        chk("poke_latency", lat, 320);
        chk("poke_ack_err_cleared", ack_err_w[0], 0);
        chk("poke_bits", mon[0].rise_sr, 32'({8'h66, 1'b0, 8'h96, 1'b0, 1'b0}));
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        chk("start_on_done_ignored", busy_w[0], 0);

        @(negedge clk);
        addr_w[0] = 7'h5A; wdata_w[0] = 8'hB5; rw_w[0] = 1'b0; start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        n = 0;
        while (mon[0].fcnt != 12 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_write", mon[0].fcnt, 12);
        rst_n = 1'b0;
        #1;
        chk("midrst_sda_oe", sda_oe_w[0], 0);
        chk("midrst_scl",    scl_w[0],    1);
        chk("midrst_busy",   busy_w[0],   0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 1'b0, 7'h0F, 8'h01, 1'b0, lat);
        chk("post_rst_latency", lat, 320);
        chk("post_rst_bits", mon[0].rise_sr, 32'({8'h1E, 1'b0, 8'h01, 1'b0, 1'b0}));
        @(negedge clk);

        txn(1, 1'b0, 7'h7F, 8'hFF, 1'b0, lat);
        chk("div1_latency", lat, 80);
        chk("div1_ack_err", ack_err_w[1], 0);
        chk("div1_bits", mon[1].rise_sr, 32'({8'hFE, 1'b0, 8'hFF, 1'b0, 1'b0}));
        chk("div1_sda_hi_changes", mon[1].hi_chg, 2);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
